// File: rtl/slow_ddr_pipelined_responder.sv
// slow_ddr_pipelined_responder: Avalon-MM slave with internal word memory standing in for a DDR controller.
// Latency: reads return exactly READ_LATENCY cycles after acceptance; writes commit at the accepting edge.
// Backpressure: waitrequest in reset, on periodic stall slots, and for reads while MAX_PENDING reads are outstanding.
module slow_ddr_pipelined_responder #(
   parameter int DATA_W       = 32,
   parameter int ADDR_W       = 8,
   parameter int READ_LATENCY = 3,
   parameter int MAX_PENDING  = 4,
   parameter int STALL_PERIOD = 0
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [ADDR_W-1:0]     address,
   input  logic [DATA_W/8-1:0]   byteenable,
   input  logic                  read,
   input  logic                  write,
   input  logic [DATA_W-1:0]     writedata,
   output logic [DATA_W-1:0]     readdata,
   output logic                  readdatavalid,
   output logic                  endofpacket,
   output logic                  waitrequest,
   output logic                  protocol_error
);

   localparam int BE_W   = DATA_W / 8;
   localparam int DEPTH  = 2 ** ADDR_W;
   localparam int PEND_W = $clog2(MAX_PENDING + 1);
   localparam int CNT_W  = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST  = (STALL_PERIOD > 1) ? CNT_W'(STALL_PERIOD - 1) : '0;
   localparam logic [PEND_W-1:0] PEND_FULL = PEND_W'(MAX_PENDING);

   logic [DATA_W-1:0]       mem [DEPTH];
   logic [CNT_W-1:0]        stall_cnt;
   logic [PEND_W-1:0]       pend_cnt;
   logic                    stall_now;
   logic                    pend_full;
   logic                    rd_acc;
   logic                    wr_acc;

   // Return pipeline: one slot per latency cycle. Data/eop only advance behind a
   // valid slot so the final stage keeps the last returned word between returns.
   logic [READ_LATENCY-1:0] pipe_vld;
   logic [READ_LATENCY-1:0] pipe_eop;
   logic [DATA_W-1:0]       pipe_dat [READ_LATENCY];

   assign stall_now = (STALL_PERIOD != 0) && (stall_cnt == CNT_LAST);
   // A return in the current cycle does not free a slot until the count has dropped.
   assign pend_full = (pend_cnt == PEND_FULL);

   // Request acceptance; a read colliding with a write is dropped in favour of the write.
   always_comb begin
      waitrequest = !reset_n || stall_now || (read && pend_full);
      wr_acc      = write && !waitrequest;
      rd_acc      = read && !write && !waitrequest;
   end

   assign readdatavalid = pipe_vld[READ_LATENCY-1];
   assign readdata      = pipe_dat[READ_LATENCY-1];
   assign endofpacket   = pipe_vld[READ_LATENCY-1] && pipe_eop[READ_LATENCY-1];

   // Free-running stall slot counter, 0..STALL_PERIOD-1.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stall_cnt <= '0;
      end else if (STALL_PERIOD == 0 || stall_cnt == CNT_LAST) begin
         stall_cnt <= '0;
      end else begin
         stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

   // Outstanding read count: up on accept, down on return, unchanged when both coincide.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pend_cnt <= '0;
      end else begin
         case ({rd_acc, readdatavalid})
            2'b10:   pend_cnt <= pend_cnt + PEND_W'(1);
            2'b01:   pend_cnt <= pend_cnt - PEND_W'(1);
            default: pend_cnt <= pend_cnt;
         endcase
      end
   end

   // Sticky flag for simultaneous read and write.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         protocol_error <= 1'b0;
      end else if (read && write) begin
         protocol_error <= 1'b1;
      end
   end

   // Byte-lane writes into the word memory; contents survive reset.
   always_ff @(posedge clk) begin
      if (wr_acc) begin
         for (int i = 0; i < BE_W; i++) begin
            if (byteenable[i]) begin
               mem[address][8*i +: 8] <= writedata[8*i +: 8];
            end
         end
      end
   end

   // Read capture at the accepting edge (sees pre-write memory) and fixed-length shift to the output.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pipe_vld <= '0;
         pipe_eop <= '0;
         for (int i = 0; i < READ_LATENCY; i++) begin
            pipe_dat[i] <= '0;
         end
      end else begin
         pipe_vld[0] <= rd_acc;
         if (rd_acc) begin
            pipe_dat[0] <= mem[address];
            pipe_eop[0] <= &address;
         end
         for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_vld[i] <= pipe_vld[i-1];
            if (pipe_vld[i-1]) begin
               pipe_dat[i] <= pipe_dat[i-1];
               pipe_eop[i] <= pipe_eop[i-1];
            end
         end
      end
   end

endmodule

// File: tb/tb_slow_ddr_pipelined_responder.sv
// Bench for slow_ddr_pipelined_responder: three instances (defaults, periodic stalls, deep latency with tight pending limit).
// Reference model: per-instance memory image plus a queue of expected returns stamped with their due cycle.
// Inputs are driven just after the falling edge; outputs are observed 1 time unit later.
module tb_slow_ddr_pipelined_responder;

   logic clk;
   logic reset_n;

   logic [7:0]  a0, a1, a2;
   logic [3:0]  be0, be1, be2;
   logic        rd0, rd1, rd2, wr0, wr1, wr2;
   logic [31:0] wd0, wd1, wd2;
   logic [31:0] rdata0, rdata1, rdata2;
   logic        rdv0, rdv1, rdv2, eop0, eop1, eop2, wait0, wait1, wait2, perr0, perr1, perr2;

   slow_ddr_pipelined_responder dut0 (
      .clk(clk), .reset_n(reset_n), .address(a0), .byteenable(be0), .read(rd0), .write(wr0),
      .writedata(wd0), .readdata(rdata0), .readdatavalid(rdv0), .endofpacket(eop0),
      .waitrequest(wait0), .protocol_error(perr0));

   slow_ddr_pipelined_responder #(.READ_LATENCY(3), .MAX_PENDING(4), .STALL_PERIOD(4)) dut1 (
      .clk(clk), .reset_n(reset_n), .address(a1), .byteenable(be1), .read(rd1), .write(wr1),
      .writedata(wd1), .readdata(rdata1), .readdatavalid(rdv1), .endofpacket(eop1),
      .waitrequest(wait1), .protocol_error(perr1));

   slow_ddr_pipelined_responder #(.READ_LATENCY(8), .MAX_PENDING(2), .STALL_PERIOD(0)) dut2 (
      .clk(clk), .reset_n(reset_n), .address(a2), .byteenable(be2), .read(rd2), .write(wr2),
      .writedata(wd2), .readdata(rdata2), .readdatavalid(rdv2), .endofpacket(eop2),
      .waitrequest(wait2), .protocol_error(perr2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          due;
      logic [31:0] d;
      logic        e;
   } ret_t;

   ret_t        q[$];
   logic [31:0] ref_mem [3][256];
   logic [31:0] last_rd [3];
   logic        exp_perr, exp_perr_now;
   int          m_cycle;
   int          obs_out;
   int          checks, passes;
   logic        obs_rdv, obs_eop, obs_wait, obs_perr;
   logic [31:0] obs_rdata;
   logic        exp_rdv, exp_eop, exp_wait, m_acc;
   logic [31:0] exp_rdata;

   function automatic int lat(input int s);
      return (s == 2) ? 8 : 3;
   endfunction

   function automatic int maxp(input int s);
      return (s == 2) ? 2 : 4;
   endfunction

   task automatic idle_inputs();
      rd0 = 0; wr0 = 0; rd1 = 0; wr1 = 0; rd2 = 0; wr2 = 0;
      a0 = 0; a1 = 0; a2 = 0; be0 = 0; be1 = 0; be2 = 0; wd0 = 0; wd1 = 0; wd2 = 0;
   endtask

   // One bus cycle on instance s: drive, observe, and advance the reference model.
   task automatic cyc(input int s, input logic rd, input logic wr, input logic [7:0] a,
                      input logic [3:0] be, input logic [31:0] wd);
      @(negedge clk);
      idle_inputs();
      case (s)
         0: begin rd0 = rd; wr0 = wr; a0 = a; be0 = be; wd0 = wd; end
         1: begin rd1 = rd; wr1 = wr; a1 = a; be1 = be; wd1 = wd; end
         default: begin rd2 = rd; wr2 = wr; a2 = a; be2 = be; wd2 = wd; end
      endcase
      #1;
      case (s)
         0: begin obs_rdv = rdv0; obs_rdata = rdata0; obs_eop = eop0; obs_wait = wait0; end
         1: begin obs_rdv = rdv1; obs_rdata = rdata1; obs_eop = eop1; obs_wait = wait1; end
         default: begin obs_rdv = rdv2; obs_rdata = rdata2; obs_eop = eop2; obs_wait = wait2; end
      endcase
      obs_perr     = perr0;
      exp_perr_now = exp_perr;
      exp_wait = ((s == 1) && (m_cycle % 4 == 3)) || (rd && q.size() == maxp(s));
      exp_rdv  = (q.size() != 0) && (q[0].due == m_cycle);
      if (exp_rdv) begin
         exp_rdata  = q[0].d;
         exp_eop    = q[0].e;
         last_rd[s] = q[0].d;
         void'(q.pop_front());
      end else begin
         exp_rdata = last_rd[s];
         exp_eop   = 1'b0;
      end
      m_acc = !exp_wait && (rd || wr);
      if (rd && !wr && !exp_wait)
         q.push_back('{due: m_cycle + lat(s), d: ref_mem[s][a], e: (a == 8'hFF)});
      if (wr && !exp_wait)
         for (int i = 0; i < 4; i++)
            if (be[i]) ref_mem[s][a][8*i +: 8] = wd[8*i +: 8];
      if (rd && wr && s == 0) exp_perr = 1'b1;
      if (rd && !wr && !obs_wait) obs_out++;
      if (obs_rdv) obs_out--;
      m_cycle++;
   endtask

   // Deassert reset on a falling edge; the first observed cycle afterwards has stall counter 1.
   task automatic release_reset();
      @(negedge clk);
      reset_n = 1'b1;
      q.delete();
      for (int s = 0; s < 3; s++) last_rd[s] = '0;
      exp_perr = 1'b0;
      obs_out  = 0;
      m_cycle  = 1;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset_n = 1'b0;
      #3;
      checks++;
      if (rdv0 !== 0 || rdata0 !== 0 || eop0 !== 0 || wait0 !== 1 || perr0 !== 0 || wait1 !== 1 || wait2 !== 1)
         $display("FAIL reset_state rdv=%b data=%h eop=%b wait=%b/%b/%b perr=%b want 0,0,0,1/1/1,0",
                  rdv0, rdata0, eop0, wait0, wait1, wait2, perr0);
      else passes++;
      release_reset();
   endtask

   task automatic test_fill();
      for (int s = 0; s < 3; s++) begin
         for (int a = 0; a < 256; a++) begin
            for (int t = 0; t < 4; t++) begin
               cyc(s, 0, 1, 8'(a), 4'hF, $urandom);
               checks++;
               if (obs_rdv !== exp_rdv || obs_wait !== exp_wait || obs_perr !== exp_perr_now)
                  $display("FAIL fill s=%0d a=%0d rdv=%b want %b wait=%b want %b perr=%b want %b",
                           s, a, obs_rdv, exp_rdv, obs_wait, exp_wait, obs_perr, exp_perr_now);
               else passes++;
               if (m_acc) break;
            end
         end
      end
   endtask

   task automatic test_single_rw();
      int k;
      cyc(0, 0, 1, 8'd5, 4'hF, 32'hDEADBEEF);
      k = m_cycle;
      cyc(0, 1, 0, 8'd5, 4'hF, 32'h0);
      repeat (6) begin
         cyc(0, 0, 0, 8'd0, 4'h0, 32'h0);
         checks++;
         if ((m_cycle - 1 == k + 3) ? (obs_rdv !== 1 || obs_rdata !== 32'hDEADBEEF || obs_eop !== 0)
                                    : (obs_rdv !== 0))
            $display("FAIL single_read cyc=%0d rdv=%b data=%h eop=%b want rdv=%0d data=deadbeef eop=0 at cyc %0d",
                     m_cycle - 1, obs_rdv, obs_rdata, obs_eop, (m_cycle - 1 == k + 3), k + 3);
         else passes++;
      end
   endtask

   task automatic test_byteenable();
      int k;
      cyc(0, 0, 1, 8'd7, 4'hF, 32'h11223344);
      cyc(0, 0, 1, 8'd7, 4'b0101, 32'hAABBCCDD);
      k = m_cycle;
      cyc(0, 1, 0, 8'd7, 4'h0, 32'h0);
      repeat (5) begin
         cyc(0, 0, 0, 8'd0, 4'h0, 32'h0);
         if (m_cycle - 1 == k + 3) begin
            checks++;
            if (obs_rdv !== 1 || obs_rdata !== 32'h11BB33DD)
               $display("FAIL byteenable rdv=%b data=%h want 1 11bb33dd", obs_rdv, obs_rdata);
            else passes++;
         end
      end
   endtask

   // Reads held high on instance s until n are accepted; every cycle checked against the model.
   task automatic burst_reads(input int s, input int n, input string name, output int stalls);
      int got;
      got    = 0;
      stalls = 0;
      for (int t = 0; t < 80 && got < n; t++) begin
         cyc(s, 1, 0, 8'($urandom), 4'h0, 32'h0);
         if (!obs_wait) got++;
         else stalls++;
         checks++;
         if (obs_rdv !== exp_rdv || obs_wait !== exp_wait || obs_eop !== exp_eop ||
             obs_rdata !== exp_rdata || obs_out > maxp(s) || obs_out < 0)
            $display("FAIL %s cyc=%0d rdv=%b/%b wait=%b/%b eop=%b/%b data=%h/%h outstanding=%0d limit %0d",
                     name, m_cycle - 1, obs_rdv, exp_rdv, obs_wait, exp_wait, obs_eop, exp_eop,
                     obs_rdata, exp_rdata, obs_out, maxp(s));
         else passes++;
      end
      checks++;
      if (got != n) $display("FAIL %s_accepts got %0d want %0d", name, got, n);
      else passes++;
   endtask

   task automatic drain(input int s, input string name);
      repeat (10) begin
         cyc(s, 0, 0, 8'd0, 4'h0, 32'h0);
         checks++;
         if (obs_rdv !== exp_rdv || obs_eop !== exp_eop || obs_rdata !== exp_rdata || obs_perr !== exp_perr_now)
            $display("FAIL %s_drain cyc=%0d rdv=%b/%b eop=%b/%b data=%h/%h perr=%b/%b", name, m_cycle - 1,
                     obs_rdv, exp_rdv, obs_eop, exp_eop, obs_rdata, exp_rdata, obs_perr, exp_perr_now);
         else passes++;
      end
   endtask

   task automatic test_back_to_back();
      int st;
      burst_reads(0, 6, "back_to_back", st);
      drain(0, "back_to_back");
   endtask

   task automatic test_random();
      logic r, w;
      for (int t = 0; t < 300; t++) begin
         r = 1'($urandom);
         w = r ? 1'b0 : ($urandom_range(0, 2) == 0);
         cyc(0, r, w, 8'($urandom), 4'($urandom), $urandom);
         checks++;
         if (obs_rdv !== exp_rdv || obs_wait !== exp_wait || obs_eop !== exp_eop ||
             obs_rdata !== exp_rdata || obs_perr !== exp_perr_now)
            $display("FAIL random cyc=%0d rdv=%b/%b wait=%b/%b eop=%b/%b data=%h/%h perr=%b/%b", m_cycle - 1,
                     obs_rdv, exp_rdv, obs_wait, exp_wait, obs_eop, exp_eop, obs_rdata, exp_rdata, obs_perr, exp_perr_now);
         else passes++;
      end
      drain(0, "random");
   endtask

   task automatic test_stall();
      int st;
      for (int t = 0; t < 24; t++) begin
         cyc(1, 1, 0, 8'($urandom), 4'h0, 32'h0);
         checks++;
         if (obs_wait !== ((m_cycle - 1) % 4 == 3) || obs_rdv !== exp_rdv || obs_rdata !== exp_rdata)
            $display("FAIL stall_slots cyc=%0d wait=%b want %b rdv=%b/%b data=%h/%h", m_cycle - 1,
                     obs_wait, ((m_cycle - 1) % 4 == 3), obs_rdv, exp_rdv, obs_rdata, exp_rdata);
         else passes++;
      end
      burst_reads(1, 5, "stall_burst", st);
      drain(1, "stall");
   endtask

   task automatic test_pending_limit();
      int st;
      burst_reads(2, 8, "pending_limit", st);
      checks++;
      if (st < 1) $display("FAIL pending_limit_stalls saw %0d waitrequest cycles want >0", st);
      else passes++;
      drain(2, "pending_limit");
   endtask

   task automatic test_protocol_error();
      int k;
      cyc(0, 1, 1, 8'd3, 4'hF, 32'hCAFEF00D);
      cyc(0, 0, 0, 8'd0, 4'h0, 32'h0);
      checks++;
      if (obs_perr !== 1'b1 || obs_rdv !== 1'b0)
         $display("FAIL protocol_error perr=%b rdv=%b want 1 0", obs_perr, obs_rdv);
      else passes++;
      k = m_cycle;
      cyc(0, 1, 0, 8'd3, 4'h0, 32'h0);
      repeat (4) cyc(0, 0, 0, 8'd0, 4'h0, 32'h0);
      checks++;
      if (obs_perr !== 1'b1) $display("FAIL perr_sticky perr=%b want 1", obs_perr);
      else passes++;
      checks++;
      if (last_rd[0] !== 32'hCAFEF00D || rdata0 !== 32'hCAFEF00D)
         $display("FAIL collide_write_data data=%h want cafef00d (read at cyc %0d)", rdata0, k);
      else passes++;
   endtask

   task automatic test_reset_midflight();
      int k;
      cyc(0, 1, 0, 8'd10, 4'h0, 32'h0);
      cyc(0, 1, 0, 8'd11, 4'h0, 32'h0);
      #2;
      reset_n = 1'b0;
      idle_inputs();
      #1;
      checks++;
      if (rdv0 !== 0 || rdata0 !== 0 || eop0 !== 0 || wait0 !== 1 || perr0 !== 0)
         $display("FAIL reset_midflight rdv=%b data=%h eop=%b wait=%b perr=%b want 0 0 0 1 0",
                  rdv0, rdata0, eop0, wait0, perr0);
      else passes++;
      release_reset();
      repeat (6) begin
         cyc(0, 0, 0, 8'd0, 4'h0, 32'h0);
         checks++;
         if (obs_rdv !== 1'b0 || obs_perr !== 1'b0)
            $display("FAIL no_return_after_reset rdv=%b perr=%b want 0 0", obs_rdv, obs_perr);
         else passes++;
      end
      cyc(0, 0, 1, 8'hFF, 4'hF, 32'h0BADCAFE);
      k = m_cycle;
      cyc(0, 1, 0, 8'hFF, 4'h0, 32'h0);
      repeat (5) begin
         cyc(0, 0, 0, 8'd0, 4'h0, 32'h0);
         checks++;
         if ((m_cycle - 1 == k + 3) ? (obs_rdv !== 1 || obs_eop !== 1 || obs_rdata !== 32'h0BADCAFE)
                                    : (obs_rdv !== 0 || obs_eop !== 0))
            $display("FAIL last_addr_eop cyc=%0d rdv=%b eop=%b data=%h want eop with data 0badcafe at cyc %0d",
                     m_cycle - 1, obs_rdv, obs_eop, obs_rdata, k + 3);
         else passes++;
      end
   endtask

   initial begin
      checks   = 0;
      passes   = 0;
      exp_perr = 1'b0;
      m_cycle  = 0;
      obs_out  = 0;
      test_reset();
      test_fill();
      test_single_rw();
      test_byteenable();
      test_back_to_back();
      test_random();
      test_stall();
      test_pending_limit();
      test_protocol_error();
      test_reset_midflight();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
